ps2_scancode_decoder: RTL and testbench

- Sits directly downstream of the PS/2 keyboard receiver FIFO.
- Pops raw scan-code bytes, folds the set-2 prefixes 0xE0 (extended) and 0xF0 (break) into single key events, and flags typematic repeats.
- Presents events through a one-entry valid/ready output register to the console and keycode-to-ASCII path.
- Also tracks the currently held key and a make counter for the display logic.

---
 rtl/ps2_scancode_decoder.sv | 164 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops raw bytes from the receiver FIFO, folds
// E0/F0 prefixes into single key events, flags typematic repeats, and tracks
// the currently held key plus a make counter.
module ps2_scancode_decoder #(
  parameter bit SUPPRESS_REPEAT = 1'b0,
  parameter int PREFIX_TIMEOUT  = 1048576,
  parameter int TO_W            = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_repeat,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] make_count
);
  typedef enum logic {S_IDLE = 1'b0, S_DECODE = 1'b1} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(PREFIX_TIMEOUT);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cur;
  logic            r_ext_pend, r_brk_pend;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_evt_valid, r_evt_ext, r_evt_break, r_evt_repeat;
  logic [7:0]      r_evt_code;
  logic            r_held_valid, r_held_ext;
  logic [7:0]      r_held_code, r_make_count;

  logic            w_slot_free, w_pop, w_decode;
  logic            w_is_e0, w_is_f0, w_is_filt, w_is_key, w_match;
  logic            w_make, w_brk, w_evt_wr, w_to_run, w_to_hit;
  logic [TO_W-1:0] w_to_inc;

  // Slot is free if empty or being drained this very cycle.
  assign w_slot_free = ~r_evt_valid | evt_ready;

  assign w_is_e0   = (r_cur == 8'hE0);
  assign w_is_f0   = (r_cur == 8'hF0);
  // Keyboard status/ack bytes and the Pause prefix never become key events.
  assign w_is_filt = (r_cur inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'hE1});
  assign w_is_key  = ~(w_is_e0 | w_is_f0 | w_is_filt);
  assign w_match   = r_held_valid & (r_held_code == r_cur) & (r_held_ext == r_ext_pend);

  assign w_make    = w_decode & w_is_key & ~r_brk_pend;
  assign w_brk     = w_decode & w_is_key & r_brk_pend;
  assign w_evt_wr  = w_brk | (w_make & ~(w_match & SUPPRESS_REPEAT));

  // Prefix timer only runs while starved for bytes with a prefix pending.
  assign w_to_run  = (r_state == S_IDLE) & ~kb_ready & (r_ext_pend | r_brk_pend);
  assign w_to_inc  = r_to_cnt + 1'b1;
  assign w_to_hit  = w_to_run & (w_to_inc == TO_LIM);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: a pop always takes exactly one decode cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: pop strobe (never during reset, so no byte is lost) and decode.
  always_comb begin
    w_pop    = 1'b0;
    w_decode = 1'b0;
    case (r_state)
      S_IDLE:   w_pop    = ~rst & kb_ready & w_slot_free;
      S_DECODE: w_decode = 1'b1;
      default:  ;
    endcase
    kb_nextdata_n = ~w_pop;
  end

  // Byte capture, prefix flags and prefix timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur      <= 8'h00;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      if (w_pop) r_cur <= kb_data;
      if (w_pop) begin
        r_to_cnt <= '0;
      end else if (w_to_hit) begin
        r_to_cnt   <= '0;
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_to_run) begin
        r_to_cnt <= w_to_inc;
      end
      if (w_decode) begin
        if (w_is_e0)      r_ext_pend <= 1'b1;
        else if (w_is_f0) r_brk_pend <= 1'b1;
        else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

  // One-entry event register; fields only change on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_valid  <= 1'b0;
      r_evt_code   <= 8'h00;
      r_evt_ext    <= 1'b0;
      r_evt_break  <= 1'b0;
      r_evt_repeat <= 1'b0;
    end else if (w_evt_wr) begin
      r_evt_valid  <= 1'b1;
      r_evt_code   <= r_cur;
      r_evt_ext    <= r_ext_pend;
      r_evt_break  <= r_brk_pend;
      r_evt_repeat <= w_make & w_match;
    end else if (evt_ready) begin
      r_evt_valid  <= 1'b0;
    end
  end

  // Held-key tracking and count of fresh (non-repeat) presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_valid <= 1'b0;
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_make_count <= 8'h00;
    end else if (w_brk & w_match) begin
      r_held_valid <= 1'b0;
    end else if (w_make & ~w_match) begin
      r_held_valid <= 1'b1;
      r_held_code  <= r_cur;
      r_held_ext   <= r_ext_pend;
      r_make_count <= r_make_count + 8'd1;
    end
  end

  assign evt_valid  = r_evt_valid;
  assign evt_code   = r_evt_code;
  assign evt_ext    = r_evt_ext;
  assign evt_break  = r_evt_break;
  assign evt_repeat = r_evt_repeat;
  assign held_valid = r_held_valid;
  assign held_code  = r_held_code;
  assign held_ext   = r_held_ext;
  assign make_count = r_make_count;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: lane 0 emits repeats, lane 1 suppresses them.
// Each lane has its own receiver FIFO and a byte-level reference model.
module tb_ps2_scancode_decoder;
  localparam int NUM_LANES = 2;
  localparam int TMO       = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_LANES-1:0] kb_ready  = '0;
  logic [NUM_LANES-1:0] evt_ready = '0;
  logic [7:0]           kb_data [NUM_LANES];
  wire  [NUM_LANES-1:0] nd, ev_v, ev_e, ev_b, ev_r, hv, he;
  wire  [7:0]           ev_c [NUM_LANES];
  wire  [7:0]           hc   [NUM_LANES];
  wire  [7:0]           mc   [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_dut
    ps2_scancode_decoder #(
      .SUPPRESS_REPEAT(i == 1), .PREFIX_TIMEOUT(TMO), .TO_W(5)
    ) u_dut (
      .clk(clk), .rst(rst),
      .kb_data(kb_data[i]), .kb_ready(kb_ready[i]), .kb_nextdata_n(nd[i]),
      .evt_valid(ev_v[i]), .evt_ready(evt_ready[i]),
      .evt_code(ev_c[i]), .evt_ext(ev_e[i]), .evt_break(ev_b[i]), .evt_repeat(ev_r[i]),
      .held_valid(hv[i]), .held_code(hc[i]), .held_ext(he[i]), .make_count(mc[i])
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int mode  = 1;                       // 0: evt_ready low, 1: high, 2: random

  logic [7:0]  fq [NUM_LANES][$];      // receiver FIFOs
  logic [10:0] lg [NUM_LANES][$];      // accepted events {code, ext, brk, rep}
  int          pops [NUM_LANES];
  bit          held_seen [NUM_LANES];
  bit          popped [NUM_LANES];

  // reference model state
  bit         m_busy [NUM_LANES];
  logic [7:0] m_cur  [NUM_LANES];
  bit         m_ext  [NUM_LANES];
  bit         m_brk  [NUM_LANES];
  int         m_to   [NUM_LANES];
  bit         m_ev_v [NUM_LANES];
  logic [10:0] m_ev  [NUM_LANES];
  bit         m_hv   [NUM_LANES];
  logic [7:0] m_hc   [NUM_LANES];
  bit         m_he   [NUM_LANES];
  logic [7:0] m_mc   [NUM_LANES];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_filt(input logic [7:0] b);
    return b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'hE1};
  endfunction

  function automatic logic [10:0] ev_at(input int l, input int i);
    if (i < lg[l].size()) return lg[l][i];
    return 11'h7FF;
  endfunction

  function automatic logic [30:0] dut_vec(input int l);
    return {nd[l], ev_v[l], ev_c[l], ev_e[l], ev_b[l], ev_r[l], hv[l], hc[l], he[l], mc[l]};
  endfunction

  // Compare this cycle's outputs with the model, then advance it over the edge.
  task automatic model_cycle(input int l);
    bit pop, wr, rep;
    logic [10:0] ev;
    logic [7:0]  c;
    pop = !rst && !m_busy[l] && kb_ready[l] && (!m_ev_v[l] || evt_ready[l]);
    tests++;
    if (dut_vec(l) !== {!pop, m_ev_v[l], m_ev[l], m_hv[l], m_hc[l], m_he[l], m_mc[l]}) begin
      fails++;
      $display("FAIL model_l%0d cyc %0d: got %h expected %h", l, cyc_n, dut_vec(l),
               {!pop, m_ev_v[l], m_ev[l], m_hv[l], m_hc[l], m_he[l], m_mc[l]});
    end
    if (rst) begin
      m_busy[l] = 0; m_cur[l] = 0; m_ext[l] = 0; m_brk[l] = 0; m_to[l] = 0;
      m_ev_v[l] = 0; m_ev[l] = 0; m_hv[l] = 0; m_hc[l] = 0; m_he[l] = 0; m_mc[l] = 0;
      return;
    end
    wr = 0; ev = 0;
    if (m_busy[l]) begin
      c = m_cur[l];
      if (c == 8'hE0) m_ext[l] = 1;
      else if (c == 8'hF0) m_brk[l] = 1;
      else begin
        if (!is_filt(c)) begin
          rep = m_hv[l] && m_hc[l] == c && m_he[l] == m_ext[l];
          if (m_brk[l]) begin
            wr = 1; ev = {c, m_ext[l], 1'b1, 1'b0};
            if (rep) m_hv[l] = 0;
          end else begin
            if (!rep) begin
              m_hv[l] = 1; m_hc[l] = c; m_he[l] = m_ext[l]; m_mc[l] = m_mc[l] + 8'd1;
            end
            if (!(rep && l == 1)) begin wr = 1; ev = {c, m_ext[l], 1'b0, rep}; end
          end
        end
        m_ext[l] = 0; m_brk[l] = 0;
      end
    end
    if (wr) begin m_ev_v[l] = 1; m_ev[l] = ev; end
    else if (evt_ready[l]) m_ev_v[l] = 0;
    if (pop) m_to[l] = 0;
    else if (!m_busy[l] && !kb_ready[l] && (m_ext[l] || m_brk[l])) begin
      m_to[l]++;
      if (m_to[l] == TMO) begin m_to[l] = 0; m_ext[l] = 0; m_brk[l] = 0; end
    end
    m_busy[l] = pop;
    if (pop) m_cur[l] = kb_data[l];
  endtask

  // Cycle engine: receivers drive after the edge, everything is checked at negedge.
  initial begin
    for (int l = 0; l < NUM_LANES; l++) kb_data[l] = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc_n++;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (popped[l] && fq[l].size() != 0) void'(fq[l].pop_front());
        kb_ready[l]  = fq[l].size() != 0;
        kb_data[l]   = kb_ready[l] ? fq[l][0] : 8'h00;
        evt_ready[l] = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      end
      @(negedge clk);
      for (int l = 0; l < NUM_LANES; l++) begin
        model_cycle(l);
        popped[l] = !nd[l];
        if (!nd[l]) pops[l]++;
        if (hv[l]) held_seen[l] = 1;
        if (ev_v[l] && evt_ready[l]) lg[l].push_back({ev_c[l], ev_e[l], ev_b[l], ev_r[l]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    for (int l = 0; l < NUM_LANES; l++) fq[l].push_back(b);
  endtask

  task automatic fresh();
    rst = 1; cyc(2); rst = 0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lg[l].delete(); pops[l] = 0; held_seen[l] = 0;
    end
  endtask

  initial begin
    cyc(1);
    chk("reset_outs", dut_vec(0), {1'b1, 30'b0});
    // make / break
    mode = 1; fresh();
    push(8'h1C); push(8'hF0); push(8'h1C); cyc(12);
    chk("mb_nevt", lg[0].size(), 2);
    chk("mb_press", ev_at(0, 0), {8'h1C, 3'b000});
    chk("mb_rel", ev_at(0, 1), {8'h1C, 3'b010});
    chk("mb_pops", pops[0], 3);
    chk("mb_mc", mc[0], 1);
    chk("mb_held_seen", held_seen[0], 1);
    chk("mb_held_end", hv[0], 0);
    // extended key, non-extended break of same code must not release it
    fresh();
    push(8'hE0); push(8'h75); cyc(10);
    chk("ext_held", {hv[0], hc[0], he[0]}, {1'b1, 8'h75, 1'b1});
    push(8'hF0); push(8'h75); cyc(10);
    chk("ext_keep", {hv[0], hc[0], he[0]}, {1'b1, 8'h75, 1'b1});
    push(8'hE0); push(8'hF0); push(8'h75); cyc(12);
    chk("ext_nevt", lg[0].size(), 3);
    chk("ext_press", ev_at(0, 0), {8'h75, 3'b100});
    chk("ext_rel", ev_at(0, 2), {8'h75, 3'b110});
    chk("ext_held_end", hv[0], 0);
    // typematic
    fresh();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); cyc(20);
    chk("typ_nevt0", lg[0].size(), 4);
    chk("typ_reps", {ev_at(0, 0), ev_at(0, 1), ev_at(0, 2)},
        {8'h1C, 3'b000, 8'h1C, 3'b001, 8'h1C, 3'b001});
    chk("typ_mc", mc[0], 1);
    chk("typ_nevt1", lg[1].size(), 2);
    chk("typ_sup_rel", ev_at(1, 1), {8'h1C, 3'b010});
    // back-pressure
    mode = 0; fresh();
    push(8'h1C); push(8'h32); cyc(10);
    chk("bp_pops1", pops[0], 1);
    chk("bp_hold", {ev_v[0], ev_c[0]}, {1'b1, 8'h1C});
    mode = 1; cyc(1); mode = 0; cyc(8);
    chk("bp_pops2", pops[0], 2);
    chk("bp_second", {ev_v[0], ev_c[0]}, {1'b1, 8'h32});
    chk("bp_acc", lg[0].size(), 1);
    // filter and prefix timeout
    mode = 1; fresh();
    push(8'hAA); push(8'hFA); cyc(10);
    chk("filt_none", lg[0].size(), 0);
    push(8'hF0); cyc(20); push(8'h1C); cyc(8);
    chk("to_press", ev_at(0, 0), {8'h1C, 3'b000});
    push(8'hF0); cyc(5); push(8'h1C); cyc(8);
    chk("to_alive", ev_at(0, 1), {8'h1C, 3'b010});
    // reset mid-operation
    mode = 0; fresh();
    push(8'h1C); cyc(5);
    chk("rst_pre", {ev_v[0], hv[0]}, 2'b11);
    rst = 1; cyc(1);
    chk("rst_outs", dut_vec(0), {1'b1, 30'b0});
    rst = 0; mode = 1;
    push(8'hE0); push(8'hF0); cyc(6);
    rst = 1; cyc(1); rst = 0;
    push(8'h1C); cyc(8);
    chk("rst_press", ev_at(0, lg[0].size() - 1), {8'h1C, 3'b000});
    // randomized traffic against the model
    mode = 2; fresh();
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0: push(8'hE0);
        1: push(8'hF0);
        2, 3: push(8'h1C);
        4: push(8'h32);
        5: push(8'h75);
        6: push(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hFA);
        default: push(8'($urandom_range(0, 255)));
      endcase
      if ($urandom_range(0, 7) == 0) cyc($urandom_range(14, 22));
      else cyc($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) begin rst = 1; cyc(1); rst = 0; end
    end
    mode = 1; cyc(80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
